bitop_arbiter: RTL and testbench
================================

# bitop_arbiter

Round-robin arbiter and sequencer sharing one bitwise logic unit (AND / OR / XOR / AND-NOT, WIDTH bits) among four requesters in the SHA-256 round datapath. It accepts one operation per cycle from the winning requester. The block computes the result into a single-entry registered output buffer, tagged with the requester ID, and holds it under downstream backpressure. It sits between the message-schedule and compression-round controllers and the shared bitwise logic.

## Interface
- WIDTH, 32, operand and result width in bits
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  4  per-requester request valid, bit i = requester i
- req_op  in  8  per-requester opcode, bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 ANDN (x & ~y)
- req_x  in  4*WIDTH  per-requester operand X, slice i = [WIDTH*i +: WIDTH]
- req_y  in  4*WIDTH  per-requester operand Y, same slicing
- req_ready  out  4  one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
- res_valid  out  1  result buffer holds a valid result
- res_id  out  2  index of the requester that issued the result
- res_data  out  WIDTH  operation result
- res_ready  in  1  downstream accepts the result when res_valid & res_ready

## Operation
- Output buffer states: EMPTY (res_valid=0) and FULL (res_valid=1).
- can_accept = EMPTY, or FULL with res_ready=1 (pass-through on the same cycle).
- Arbitration, combinational:
  - The search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... mod 4.
  - The first i with req_valid[i]=1 wins.
  - req_ready = onehot(winner) when can_accept and any req_valid; else 0.
- req_ready depends only on req_valid, rr_ptr and buffer state, never on req_op or operand values.
- On accept of requester i:
  - res_data <= f(req_op[i], req_x[i], req_y[i]).
  - res_id <= i.
  - Buffer goes to FULL.
  - rr_ptr <= (i+1) mod 4.
- FULL with res_ready=1 and no accept: buffer goes to EMPTY.
- FULL with res_ready=0: res_valid, res_id and res_data hold stable.
- rr_ptr changes only on accept.
- Requesters may drop req_valid without a grant; no ordering is required of them.
- Reset values: res_valid=0, res_id=0, res_data=0, rr_ptr=0, req_ready=0. Reset mid-operation discards any buffered result.

## Timing
- Latency: accept at edge N gives res_valid=1 with the result after edge N.
- Throughput: 1 operation per cycle while res_ready=1.
- Simultaneous drain and accept in the same cycle: the buffer stays FULL with the new result; there are no bubbles.
- Starvation bound: a continuously valid requester is granted within 4 accepts.
- resetn assert is asynchronous. Deassert is sampled synchronously, and the first grant is possible on the first edge after release.

## Configuration
- BITOP_ARB_STATS_EN defined:
  - Adds ports stat_sel (in, 2) and stat_count (out, 16).
  - Keeps four 16-bit grant counters, one per requester. Each increments on accept and saturates at 16'hFFFF.
  - stat_count = counter[stat_sel], combinational.
  - Counters reset to 0 on resetn.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Single op:
  - Stimulus: after reset, req_valid=4'b0010, op=00, x=32'hF0F0_1234, y=32'h0FF0_FFFF.
  - Response: req_ready=4'b0010. Next cycle res_valid=1, res_id=1, res_data=32'h00F0_1234. rr_ptr becomes 2.
- Opcode coverage:
  - Stimulus: x=32'hAAAA_5555, y=32'h0F0F_0F0F, one accepted request each for op 00/01/10/11.
  - Response: 0A0A_0505 / AFAF_5F5F / A5A5_5A5A / A0A0_5050.
- Round-robin fairness:
  - Stimulus: req_valid=4'b1111 held and res_ready=1 for 8 cycles.
  - Response: res_id sequence 0,1,2,3,0,1,2,3 with res_valid continuously 1.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles with all requesters valid.
  - Response: after the first accept, req_ready=0 and res_data/res_id stay stable. When res_ready rises, drain and accept happen on the same edge.
- Reset mid-operation:
  - Stimulus: assert resetn=0 asynchronously while FULL, between clock edges.
  - Response: res_valid=0 and req_ready=0 immediately. After release, requester 0 wins first with 4'b1111 valid.
- Stats build (BITOP_ARB_STATS_EN):
  - Stimulus: 70000 accepts of requester 2.
  - Response: stat_sel=2 reads 16'hFFFF, other counters 0.

Source files
------------

// File: rtl/bitop_arbiter.sv
// Round-robin arbiter sharing one AND/OR/XOR/ANDN unit among four requesters; optional grant stats via BITOP_ARB_STATS_EN.
// One-cycle latency into a single-entry result buffer; grants stop while the buffer is full and res_ready is low.
module bitop_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [3:0]         req_valid,
  input  logic [7:0]         req_op,
  input  logic [4*WIDTH-1:0] req_x,
  input  logic [4*WIDTH-1:0] req_y,
  output logic [3:0]         req_ready,
  output logic               res_valid,
  output logic [1:0]         res_id,
  output logic [WIDTH-1:0]   res_data,
  input  logic               res_ready
`ifdef BITOP_ARB_STATS_EN
  ,
  input  logic [1:0]         stat_sel,
  output logic [15:0]        stat_count
`endif
);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t       state, state_nxt;
  logic [1:0]       rr_ptr;
  logic [1:0]       win_id;
  logic [1:0]       cand;
  logic             win_found;
  logic             can_accept;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_x, sel_y, alu_out;

  // Walk from the highest offset down so the first valid requester after rr_ptr is the last one kept.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr;
    cand      = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + k[1:0];
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Reset gates the grant so nothing is offered while resetn is low.
  assign can_accept = resetn && ((state == EMPTY) || res_ready);
  assign accept     = can_accept && win_found;

  always_comb begin
    req_ready = 4'b0000;
    if (accept) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    sel_op = req_op[2*win_id +: 2];
    sel_x  = req_x[WIDTH*win_id +: WIDTH];
    sel_y  = req_y[WIDTH*win_id +: WIDTH];
    case (sel_op)
      2'b00:   alu_out = sel_x & sel_y;
      2'b01:   alu_out = sel_x | sel_y;
      2'b10:   alu_out = sel_x ^ sel_y;
      default: alu_out = sel_x & ~sel_y;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (!accept && res_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      rr_ptr   <= 2'd0;
      res_id   <= 2'd0;
      res_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr   <= win_id + 2'd1;
        res_id   <= win_id;
        res_data <= alu_out;
      end
    end
  end

  assign res_valid = (state == FULL);

`ifdef BITOP_ARB_STATS_EN
  logic [15:0] grant_cnt [4];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) grant_cnt[i] <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && win_id == i[1:0] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  assign stat_count = grant_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_bitop_arbiter.sv
// Directed bench for bitop_arbiter: reset, single op, opcodes, round robin, backpressure, async reset, optional stats.
module tb_bitop_arbiter;
  localparam int WIDTH = 32;

  logic               clock = 1'b0;
  logic               resetn;
  logic [3:0]         req_valid;
  logic [7:0]         req_op;
  logic [4*WIDTH-1:0] req_x, req_y;
  logic [3:0]         req_ready;
  logic               res_valid;
  logic [1:0]         res_id;
  logic [WIDTH-1:0]   res_data;
  logic               res_ready;
`ifdef BITOP_ARB_STATS_EN
  logic [1:0]         stat_sel;
  logic [15:0]        stat_count;
`endif

  int passed = 0;
  int total  = 0;

  bitop_arbiter #(.WIDTH(WIDTH)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .res_ready(res_ready)
`ifdef BITOP_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    resetn = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
    req_op = '0; req_x = '0; req_y = '0;
    #3;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", res_valid); else passed++;
    total++; if (res_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", res_id); else passed++;
    total++; if (res_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", res_data); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else passed++;
    @(negedge clock);
    req_valid = 4'b0000;
    resetn = 1'b1;
  endtask

  task automatic test_single_op();
    @(negedge clock);
    req_valid = 4'b0010; req_op = 8'h00;
    req_x[WIDTH*1 +: WIDTH] = 32'hF0F0_1234;
    req_y[WIDTH*1 +: WIDTH] = 32'h0FF0_FFFF;
    #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", req_ready); else passed++;
    @(posedge clock); #1;
    total++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", res_valid); else passed++;
    total++; if (res_id !== 2'd1) $display("FAIL single_id: got %0d expected 1", res_id); else passed++;
    total++; if (res_data !== 32'h00F0_1234) $display("FAIL single_data: got %h expected 00f01234", res_data); else passed++;
    @(negedge clock);
    req_valid = 4'b0000;
    @(negedge clock);
    // Buffer drained; pointer should now be at requester 2.
    total++; if (res_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", res_valid); else passed++;
    req_valid = 4'b1111; #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL single_rrptr: got %b expected 0100", req_ready); else passed++;
    req_valid = 4'b0000;
  endtask

  task automatic test_opcodes();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h0A0A_0505; exp_tab[1] = 32'hAFAF_5F5F;
    exp_tab[2] = 32'hA5A5_5A5A; exp_tab[3] = 32'hA0A0_5050;
    req_x[WIDTH*2 +: WIDTH] = 32'hAAAA_5555;
    req_y[WIDTH*2 +: WIDTH] = 32'h0F0F_0F0F;
    for (int op = 0; op < 4; op++) begin
      @(negedge clock);
      req_valid = 4'b0100;
      req_op[5:4] = op[1:0];
      @(posedge clock); #1;
      total++;
      if (res_data !== exp_tab[op] || res_id !== 2'd2)
        $display("FAIL opcode_%0d: got id %0d data %h expected id 2 data %h", op, res_id, res_data, exp_tab[op]);
      else passed++;
    end
    @(negedge clock);
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    // Pointer is at 3: one grant to requester 3 brings it back to 0.
    @(negedge clock);
    req_valid = 4'b1000;
    @(negedge clock);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      total++;
      if (res_valid !== 1'b1 || res_id !== c[1:0])
        $display("FAIL rr_cycle%0d: got valid %b id %0d expected valid 1 id %0d", c, res_valid, res_id, c % 4);
      else passed++;
    end
    @(negedge clock);
    req_valid = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_back_to_back_backpressure();
    req_op = 8'b01_01_01_01;
    for (int i = 0; i < 4; i++) begin
      req_x[WIDTH*i +: WIDTH] = 32'h1111_0000 * (i + 1) + 32'h0000_00C0 + i;
      req_y[WIDTH*i +: WIDTH] = 32'h0;
    end
    res_ready = 1'b0; req_valid = 4'b1111; #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL bp_first_ready: got %b expected 0001", req_ready); else passed++;
    @(posedge clock); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready_c%0d: got %b expected 0000", c, req_ready); else passed++;
      @(posedge clock); #1;
      total++;
      if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 32'h1111_00C0)
        $display("FAIL bp_hold_c%0d: got v%b id %0d data %h expected v1 id 0 data 111100c0", c, res_valid, res_id, res_data);
      else passed++;
    end
    @(negedge clock);
    res_ready = 1'b1; #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL bp_passthru_ready: got %b expected 0010", req_ready); else passed++;
    @(posedge clock); #1;
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 32'h2222_00C1)
      $display("FAIL bp_passthru: got v%b id %0d data %h expected v1 id 1 data 222200c1", res_valid, res_id, res_data);
    else passed++;
  endtask

  task automatic test_reset_mid();
    // Buffer is full (id 1), pointer at 2; stall it then reset between edges.
    @(negedge clock);
    res_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (res_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", res_valid); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL rstmid_ready: got %b expected 0000", req_ready); else passed++;
    @(negedge clock);
    resetn = 1'b1; res_ready = 1'b1; req_valid = 4'b1111; #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL rstmid_first: got %b expected 0001", req_ready); else passed++;
    @(posedge clock); #1;
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd0)
      $display("FAIL rstmid_result: got v%b id %0d expected v1 id 0", res_valid, res_id);
    else passed++;
    @(negedge clock);
    req_valid = 4'b0000;
    @(negedge clock);
  endtask

`ifdef BITOP_ARB_STATS_EN
  task automatic test_stats();
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1; res_ready = 1'b1; req_valid = 4'b0100;
    repeat (70000) @(negedge clock);
    req_valid = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      stat_sel = s[1:0]; #1;
      total++;
      if (stat_count !== ((s == 2) ? 16'hFFFF : 16'h0000))
        $display("FAIL stats_sel%0d: got %h expected %h", s, stat_count, (s == 2) ? 16'hFFFF : 16'h0000);
      else passed++;
    end
  endtask
`endif

  initial begin
`ifdef BITOP_ARB_STATS_EN
    stat_sel = 2'd0;
`endif
    test_reset();
    test_single_op();
    test_opcodes();
    test_round_robin();
    test_back_to_back_backpressure();
    test_reset_mid();
`ifdef BITOP_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
